// File: rtl/home_controller_seq_pkg.sv
// home_ctrl_pkg
// Shared types and helpers for the sequential home controller:
//   alarm_state_t  - 2-bit alarm FSM encoding, also driven out on alarmState
//   cnt_width()    - bit width able to hold 0..max_val inclusive
package home_ctrl_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } alarm_state_t;

    // Never narrower than one bit, so a degenerate maximum still gives a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/home_controller_seq_if.sv
// home_controller_seq_if
// Bundles the sensor inputs and actuator outputs of one home controller.
//   master : sensor front-end / actuator side (drives pir, isDark, tempValue, authorized)
//   slave  : the controller (drives lightOn, fanOn, alarmOn, alarmState, alarmZone)
interface home_controller_seq_if
    import home_ctrl_pkg::*;
#(
    parameter int NUM_ZONES = 4,
    parameter int TEMP_W    = 8
);
    logic [NUM_ZONES-1:0] pir;
    logic [NUM_ZONES-1:0] isDark;
    logic [TEMP_W-1:0]    tempValue;
    logic                 authorized;
    logic [NUM_ZONES-1:0] lightOn;
    logic                 fanOn;
    logic                 alarmOn;
    alarm_state_t         alarmState;
    logic [NUM_ZONES-1:0] alarmZone;

    modport master (
        output pir, isDark, tempValue, authorized,
        input  lightOn, fanOn, alarmOn, alarmState, alarmZone
    );

    modport slave (
        input  pir, isDark, tempValue, authorized,
        output lightOn, fanOn, alarmOn, alarmState, alarmZone
    );

endinterface

// File: rtl/home_controller_seq_pir_debounce.sv
// pir_debounce
// Brings one asynchronous PIR line into the clock domain and filters it.
//   clk, rst   : system clock, asynchronous active-high reset
//   pir        : raw asynchronous motion input
//   debounced  : filtered motion, changes only after DEBOUNCE_CYCLES stable cycles
module pir_debounce
    import home_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pir,
    output logic debounced
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pir;
            sync_2 <= sync_1;
        end
    end

    // The counter holds how many mismatching cycles have already been seen, so
    // the DEBOUNCE_CYCLES-th consecutive mismatch is the one that flips the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_count <= '0;
            debounced    <= 1'b0;
        end else if (sync_2 == debounced) begin
            stable_count <= '0;
        end else if (stable_count == LAST_COUNT) begin
            stable_count <= '0;
            debounced    <= sync_2;
        end else begin
            stable_count <= stable_count + CW'(1);
        end
    end

endmodule

// File: rtl/home_controller_seq.sv
// home_controller_seq
// Multi-zone home controller: per-zone lights with retriggerable hold timers,
// a fan with threshold hysteresis and an intrusion alarm with entry delay.
//   clk, rst         : system clock, asynchronous active-high reset
//   bus.pir          : raw motion per zone (asynchronous)
//   bus.isDark       : darkness flag per zone
//   bus.tempValue    : unsigned temperature
//   bus.authorized   : 1 = occupant authorized / system disarmed
//   bus.lightOn      : per-zone light enable
//   bus.fanOn        : fan enable
//   bus.alarmOn      : siren enable
//   bus.alarmState   : current alarm FSM state
//   bus.alarmZone    : one-hot zone that started the entry delay, else 0
module home_controller_seq
    import home_ctrl_pkg::*;
#(
    parameter int                NUM_ZONES          = 4,
    parameter int                DEBOUNCE_CYCLES    = 8,
    parameter int                LIGHT_HOLD_CYCLES  = 1000,
    parameter int                ENTRY_DELAY_CYCLES = 500,
    parameter int                TEMP_W             = 8,
    parameter logic [TEMP_W-1:0] FAN_ON_TH          = TEMP_W'(30),
    parameter logic [TEMP_W-1:0] FAN_OFF_TH         = TEMP_W'(27)
) (
    input logic               clk,
    input logic               rst,
    home_controller_seq_if.slave bus
);

    localparam int HW = cnt_width(LIGHT_HOLD_CYCLES);
    localparam int EW = cnt_width(ENTRY_DELAY_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(LIGHT_HOLD_CYCLES);
    localparam logic [EW-1:0] ENTRY_LOAD = EW'(ENTRY_DELAY_CYCLES);

    if (FAN_OFF_TH >= FAN_ON_TH || NUM_ZONES < 1 || NUM_ZONES > 16 ||
        DEBOUNCE_CYCLES < 1 || LIGHT_HOLD_CYCLES < 1 || ENTRY_DELAY_CYCLES < 1) begin : g_bad_params
        $error("home_controller_seq: illegal parameter combination");
    end

    logic [NUM_ZONES-1:0] pir_deb;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        pir_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .pir       (bus.pir[z]),
            .debounced (pir_deb[z])
        );
    end

    // ---------------- lights ----------------
    logic [HW-1:0]        hold_timer [NUM_ZONES];
    logic [HW-1:0]        hold_next  [NUM_ZONES];
    logic [NUM_ZONES-1:0] light_next;

    // lightOn is registered from the next timer value so it tracks the timer
    // without an extra cycle of lag.
    always_comb begin
        for (int z = 0; z < NUM_ZONES; z++) begin
            hold_next[z] = hold_timer[z];
            if (!bus.isDark[z]) begin
                hold_next[z] = '0;
            end else if (pir_deb[z]) begin
                hold_next[z] = HOLD_LOAD;
            end else if (hold_timer[z] != '0) begin
                hold_next[z] = hold_timer[z] - HW'(1);
            end
            light_next[z] = (hold_next[z] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                hold_timer[z] <= '0;
            end
            bus.lightOn <= '0;
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                hold_timer[z] <= hold_next[z];
            end
            bus.lightOn <= light_next;
        end
    end

    // ---------------- fan ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fanOn <= 1'b0;
        end else if (bus.tempValue >= FAN_ON_TH) begin
            bus.fanOn <= 1'b1;
        end else if (bus.tempValue <= FAN_OFF_TH) begin
            bus.fanOn <= 1'b0;
        end
    end

    // ---------------- alarm ----------------
    alarm_state_t         state;
    alarm_state_t         state_next;
    logic [EW-1:0]        entry_count;
    logic [EW-1:0]        entry_next;
    logic [NUM_ZONES-1:0] zone_next;
    logic [NUM_ZONES-1:0] lowest_zone;
    logic                 any_motion;

    assign any_motion     = |pir_deb;
    // Two's-complement trick isolates the lowest set bit.
    assign lowest_zone    = pir_deb & (~pir_deb + NUM_ZONES'(1));
    assign bus.alarmState = state;

    always_comb begin
        state_next = state;
        entry_next = entry_count;
        zone_next  = bus.alarmZone;
        unique case (state)
            DISARMED: begin
                zone_next = '0;
                if (!bus.authorized) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (bus.authorized) begin
                    state_next = DISARMED;
                    zone_next  = '0;
                end else if (any_motion) begin
                    state_next = ENTRY;
                    entry_next = ENTRY_LOAD;
                    zone_next  = lowest_zone;
                end
            end
            ENTRY: begin
                if (bus.authorized) begin
                    state_next = DISARMED;
                    entry_next = '0;
                    zone_next  = '0;
                end else if (entry_count <= EW'(1)) begin
                    state_next = ALARM;
                    entry_next = '0;
                end else begin
                    entry_next = entry_count - EW'(1);
                end
            end
            ALARM: begin
                if (bus.authorized) begin
                    state_next = DISARMED;
                    zone_next  = '0;
                end
            end
            default: begin
                state_next = DISARMED;
                entry_next = '0;
                zone_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= DISARMED;
            entry_count   <= '0;
            bus.alarmZone <= '0;
            bus.alarmOn   <= 1'b0;
        end else begin
            state         <= state_next;
            entry_count   <= entry_next;
            bus.alarmZone <= zone_next;
            bus.alarmOn   <= (state_next == ALARM);
        end
    end

endmodule

// File: doc/home_controller_seq.md
# home_controller_seq

Sequential, multi-zone successor to the combinational home decision logic. It takes NUM_ZONES PIR sensors and per-zone darkness flags, a raw temperature reading and an authorization level, and drives per-zone lights with retriggerable hold timers, a fan with threshold hysteresis, and an intrusion alarm with an arming state machine and entry delay. It sits between the sensor front-end and the actuator drivers, one instance per dwelling.

## Interface
Parameters:
- NUM_ZONES, 4: number of PIR/light zones (1..16).
- DEBOUNCE_CYCLES, 8: consecutive stable cycles needed to accept a PIR change (≥1).
- LIGHT_HOLD_CYCLES, 1000: light on-time after the last debounced motion (≥1).
- ENTRY_DELAY_CYCLES, 500: grace period from armed-motion to alarm (≥1).
- TEMP_W, 8: temperature width.
- FAN_ON_TH, 8'd30 / FAN_OFF_TH, 8'd27: hysteresis thresholds, unsigned, FAN_OFF_TH < FAN_ON_TH (elaboration error otherwise).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- pir  in  NUM_ZONES  raw, asynchronous motion per zone.
- isDark  in  NUM_ZONES  synchronous darkness flag per zone.
- tempValue  in  TEMP_W  synchronous unsigned temperature.
- authorized  in  1  synchronous level; 1 = occupant authorized/disarmed.
- lightOn  out  NUM_ZONES  per-zone light enable, registered.
- fanOn  out  1  fan enable, registered.
- alarmOn  out  1  siren enable, registered.
- alarmState  out  2  current alarm FSM state encoding.
- alarmZone  out  NUM_ZONES  one-hot zone that started the entry delay; 0 otherwise.

## Operation
- Reset values: lightOn=0, fanOn=0, alarmOn=0, alarmState=DISARMED (2'd0), alarmZone=0; all timers and debounce counters 0; synchronizers and debounced PIR 0.
- PIR path per zone: 2-flop synchronizer, then debounce: counter increments while sync ≠ debounced, clears when equal; when it reaches DEBOUNCE_CYCLES the debounced value flips and counter clears.
- Lights per zone: if debounced PIR=1 and isDark=1, hold timer loads LIGHT_HOLD_CYCLES (reloads every such cycle); else decrements if nonzero. isDark=0 clears timer immediately. lightOn = registered (timer ≠ 0).
- Fan: if tempValue ≥ FAN_ON_TH set fanOn; else if tempValue ≤ FAN_OFF_TH clear; otherwise hold.
- Alarm FSM (any = OR of debounced PIR):
  - DISARMED (0): authorized=0 → ARMED.
  - ARMED (1): authorized=1 → DISARMED; else any=1 → ENTRY, load entry counter with ENTRY_DELAY_CYCLES, latch alarmZone = lowest-index active zone.
  - ENTRY (2): authorized=1 → DISARMED (clears alarmZone); else counter decrements; at 1 → ALARM.
  - ALARM (3): alarmOn=1; latched regardless of PIR; authorized=1 → DISARMED, alarmOn=0, alarmZone=0.
- authorized has priority over motion in every state.

## Timing
- pir edge to debounced change: 2 sync cycles + DEBOUNCE_CYCLES; lightOn follows 1 cycle later (total 3+DEBOUNCE_CYCLES edges for a clean edge).
- Light stays on exactly LIGHT_HOLD_CYCLES cycles after debounced PIR falls (with isDark held 1); isDark fall → lightOn low next cycle.
- fanOn updates 1 cycle after tempValue crosses a threshold.
- ARMED→ENTRY one cycle after debounced motion; ENTRY lasts ENTRY_DELAY_CYCLES cycles; alarmOn rises on the cycle ALARM is entered.
- Glitches shorter than DEBOUNCE_CYCLES never reach lights or the FSM.
- Counter widths: $clog2(max+1) of their parameter; no wrap-around (decrement saturates at 0).
- rst mid-operation: all state returns to reset values asynchronously; deassertion synchronous to clk by the system reset block.

## Structure
- Package home_ctrl_pkg: alarm state enum (DISARMED/ARMED/ENTRY/ALARM, 2-bit), width helper function.
- Sub-module pir_debounce (synchronizer + debounce counter, parameter DEBOUNCE_CYCLES), instantiated NUM_ZONES times via generate. Light timers, fan and FSM live in the top.

## Test plan
- Zone 0 pir pulse 5 cycles, DEBOUNCE_CYCLES=8 → no lightOn, FSM stays ARMED.
- isDark[1]=1, pir[1] high 20 cycles then low, LIGHT_HOLD_CYCLES=1000 → lightOn[1] rises 11 cycles after pir, falls 1000 cycles after debounced fall.
- tempValue ramps 25→31→28→26 → fanOn rises at 30, stays on at 28, falls at 27-or-below (26).
- authorized=0, pir[2] motion, ENTRY_DELAY_CYCLES=500 → alarmState=2, alarmZone=4'b0100, alarmOn=1 after 500 cycles; authorized=1 → DISARMED, all clear next cycle.
- Motion in ENTRY then authorized=1 at cycle 100 → DISARMED, alarmOn never asserts.
- rst asserted in ALARM with lights on → all outputs 0 immediately, alarmState=0.
